// File: rtl/axis_scrambler_pkg.sv
// Shared types, mode codes and the word-wide LFSR step for axis_scrambler_gen.
package axis_scrambler_pkg;

  localparam int unsigned MAX_LEN   = 32;
  localparam int unsigned MAX_WIDTH = 128;

  localparam logic [1:0] MODE_ADDITIVE      = 2'd0;
  localparam logic [1:0] MODE_SELFSYNC_SCR  = 2'd1;
  localparam logic [1:0] MODE_SELFSYNC_DSCR = 2'd2;

  // Occupancy of the output register plus skid entry
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Result of one word step: advanced state and the scrambled word
  typedef struct packed {
    logic [MAX_LEN-1:0]   state;
    logic [MAX_WIDTH-1:0] data;
  } lfsr_word_t;

  // Bit-serial recurrence unrolled over one word; bit 0 is first in time
  function automatic lfsr_word_t lfsr_step_word(
    input logic [MAX_LEN-1:0]   state,
    input logic [MAX_WIDTH-1:0] data,
    input logic [MAX_LEN-1:0]   taps,
    input logic [1:0]           mode,
    input int unsigned          width,
    input int unsigned          len
  );
    lfsr_word_t         res;
    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] st;
    logic               fb;
    logic               ob;
    logic               sh;
    mask = '1;
    if (len < MAX_LEN) mask = (MAX_LEN'(1) << len) - MAX_LEN'(1);
    st  = state & mask;
    res = '0;
    for (int unsigned b = 0; b < MAX_WIDTH; b++) begin
      if (b < width) begin
        fb = ^(st & taps);
        ob = data[b] ^ fb;
        res.data[b] = ob;
        case (mode)
          MODE_SELFSYNC_SCR:  sh = ob;
          MODE_SELFSYNC_DSCR: sh = data[b];
          default:            sh = fb;
        endcase
        st = {st[MAX_LEN-2:0], sh} & mask;
      end
    end
    res.state = st;
    return res;
  endfunction

endpackage

// File: rtl/axis_scrambler_gen_if.sv
// AXI-Stream beat bundle used on both sides of the scrambler.
interface axis_scrambler_gen_if #(
  parameter int unsigned WIDTH = 24
) ();
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_scrambler_gen_skid.sv
// Registered output stage with one skid entry; ready is a register that is
// high exactly when the skid entry is free.
module axis_skid_buffer
  import axis_scrambler_pkg::*;
#(
  parameter int unsigned WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  occ_e             occ_q, occ_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             ready_q;
  logic             valid_q;
  logic             accept;
  logic             drain;

  // State and data registers; ready/valid are registered decodes of next occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q   <= OCC_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= (occ_d != OCC_TWO);
      valid_q <= (occ_d != OCC_EMPTY);
    end
  end

  // Occupancy transitions: fill output first, spill to skid under stall
  always_comb begin
    occ_d  = occ_q;
    out_d  = out_q;
    skid_d = skid_q;
    accept = in_valid && ready_q;
    drain  = valid_q && out_ready;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) begin
          out_d = in_data;
          occ_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (accept && drain) begin
          out_d = in_data;
        end else if (accept) begin
          skid_d = in_data;
          occ_d  = OCC_TWO;
        end else if (drain) begin
          occ_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (drain) begin
          out_d = skid_q;
          occ_d = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_data  = out_q;

endmodule

// File: rtl/axis_scrambler_gen.sv
// Generalised AXI-Stream scrambler/descrambler (additive or self-synchronising).
// Optional runtime seed port enabled by defining AXIS_SCRAMBLER_SEED_PORT_EN.
module axis_scrambler_gen
  import axis_scrambler_pkg::*;
#(
  parameter int unsigned         WIDTH        = 24,
  parameter int unsigned         LFSR_LEN     = 7,
  parameter logic [LFSR_LEN-1:0] TAPS         = 7'b1001000,
  parameter logic [LFSR_LEN-1:0] SEED         = 7'b1011101,
  parameter int unsigned         MODE         = 0,
  parameter int unsigned         FRAME_RELOAD = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
`ifdef AXIS_SCRAMBLER_SEED_PORT_EN
  input  logic [LFSR_LEN-1:0] cfg_seed,
  input  logic                cfg_seed_load,
`endif
  axis_scrambler_gen_if.slave  s_axis,
  axis_scrambler_gen_if.master m_axis
);

  // Parameter sanity
  if (LFSR_LEN < 2 || LFSR_LEN > MAX_LEN) begin : g_err_len
    $error("axis_scrambler_gen: LFSR_LEN must be in 2..32");
  end
  if (TAPS == '0) begin : g_err_taps
    $error("axis_scrambler_gen: TAPS must be non-zero");
  end
  if (MODE > 2) begin : g_err_mode
    $error("axis_scrambler_gen: MODE must be 0, 1 or 2");
  end
  if (MODE == 0 && SEED == '0) begin : g_err_seed
    $error("axis_scrambler_gen: additive mode needs a non-zero SEED");
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_err_width
    $error("axis_scrambler_gen: WIDTH out of supported range");
  end

  logic                accept;
  logic [LFSR_LEN-1:0] st_q, st_d;
  logic [LFSR_LEN-1:0] next_st;
  logic [LFSR_LEN-1:0] reload_seed;
  logic [WIDTH-1:0]    out_word;
  logic [WIDTH:0]      m_beat;
  lfsr_word_t          step;
  logic                unused_step;

  assign accept = s_axis.tvalid && s_axis.tready;

  // Whole-word recurrence from the current state
  assign step        = lfsr_step_word(MAX_LEN'(st_q), MAX_WIDTH'(s_axis.tdata), MAX_LEN'(TAPS),
                                      2'(MODE), WIDTH, LFSR_LEN);
  assign next_st     = step.state[LFSR_LEN-1:0];
  assign out_word    = step.data[WIDTH-1:0];
  assign unused_step = ^step;

`ifdef AXIS_SCRAMBLER_SEED_PORT_EN
  logic [LFSR_LEN-1:0] seed_q;

  // Last loaded runtime seed, used for frame reloads
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seed_q <= SEED;
    end else if (cfg_seed_load) begin
      seed_q <= cfg_seed;
    end
  end

  assign reload_seed = seed_q;
`else
  assign reload_seed = SEED;
`endif

  // Next state: advance on accept, frame reload on tlast, runtime load wins
  always_comb begin
    st_d = st_q;
    if (accept) begin
      if (FRAME_RELOAD != 0 && s_axis.tlast) st_d = reload_seed;
      else                                   st_d = next_st;
    end
`ifdef AXIS_SCRAMBLER_SEED_PORT_EN
    if (cfg_seed_load) st_d = cfg_seed;
`endif
  end

  // LFSR state register
  always_ff @(posedge aclk) begin
    if (!aresetn) st_q <= SEED;
    else          st_q <= st_d;
  end

  axis_skid_buffer #(
    .WIDTH(WIDTH + 1)
  ) u_skid (
    .clk      (aclk),
    .rst_n    (aresetn),
    .in_data  ({s_axis.tlast, out_word}),
    .in_valid (s_axis.tvalid),
    .in_ready (s_axis.tready),
    .out_data (m_beat),
    .out_valid(m_axis.tvalid),
    .out_ready(m_axis.tready)
  );

  assign {m_axis.tlast, m_axis.tdata} = m_beat;

endmodule
